// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider, one quotient bit per cycle, MSB first.
// Define DIV32_SEQ_SIGNED_EN to honour the sign port (truncating signed divide).
module div32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);
  // state | meaning
  // IDLE  | waiting for start; operands latched on the start edge
  // CALC  | 32 restoring-division steps in progress
  // DONE  | results valid, done pulses for one cycle
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic        q_neg, r_neg;
  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, diff;
  logic        q_bit;
  logic [31:0] q_fin, r_fin, q_res, r_res;

`ifdef DIV32_SEQ_SIGNED_EN
  assign signed_op = sign;
`else
  assign signed_op = sign & 1'b0;
`endif

  always_comb begin
    a_mag  = (signed_op && a[31]) ? -a : a;
    b_mag  = (signed_op && b[31]) ? -b : b;
    rem_sh = {rem, dvd[31]};
    diff   = rem_sh - {1'b0, dvs};
    q_bit  = ~diff[32];
    q_fin  = {dvd[30:0], q_bit};
    r_fin  = q_bit ? diff[31:0] : rem_sh[31:0];
    q_res  = q_neg ? -q_fin : q_fin;
    r_res  = r_neg ? -r_fin : r_fin;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (b == 32'd0) ? DONE : CALC;
      CALC: if (cnt == 5'd31) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd   <= a_mag;
          dvs   <= b_mag;
          rem   <= '0;
          cnt   <= '0;
          q_neg <= signed_op & (a[31] ^ b[31]);
          r_neg <= signed_op & a[31];
          if (b == 32'd0) begin
            quotient  <= '1;
            remainder <= a;
            div_zero  <= 1'b1;
          end
        end
        CALC: begin
          // dvd doubles as the quotient shift register as dividend bits drain out
          rem <= r_fin;
          dvd <= q_fin;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            quotient  <= q_res;
            remainder <= r_res;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed operations with a scoreboard queue.
// Honours DIV32_SEQ_SIGNED_EN to select the expected signed/unsigned behaviour.
module tb_div32_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  div32_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    logic sg;
    logic [31:0] mx, my, q, r;
    sg = s;
`ifndef DIV32_SEQ_SIGNED_EN
    sg = 1'b0;
`endif
    if (y == 32'd0) begin
      e.q = 32'hFFFFFFFF; e.r = x; e.dz = 1'b1; e.lat = 1;
      return e;
    end
    mx = (sg && x[31]) ? -x : x;
    my = (sg && y[31]) ? -y : y;
    q = mx / my;
    r = mx % my;
    if (sg && (x[31] ^ y[31])) q = -q;
    if (sg && x[31]) r = -r;
    e.q = q; e.r = r; e.dz = 1'b0; e.lat = 33;
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input int glitch_at, input logic [31:0] gx,
                        input logic [31:0] gy, input int idle_cycles);
    exp_t g;
    int c, busy_cnt, extra;
    logic [31:0] q_hold;
    bit seen;
    @(negedge clk);
    a = x; b = y; sign = s; start = 1'b1;
    sb.push_back(model(x, y, s));
    @(posedge clk);
    #1 start = 1'b0;
    c = 0; busy_cnt = 0; seen = 0;
    while (!seen && c < 60) begin
      @(negedge clk);
      c++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
      if (c == glitch_at) begin
        a = gx; b = gy; start = 1'b1;
      end else begin
        start = 1'b0;
        a = $urandom; b = $urandom; sign = 1'(($urandom) & 1);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    g = sb.pop_front();
    chk({tag, "_latency"}, c, g.lat);
    chk({tag, "_busy_cycles"}, busy_cnt, g.lat - 1);
    chk({tag, "_quotient"}, quotient, g.q);
    chk({tag, "_remainder"}, remainder, g.r);
    chk({tag, "_div_zero"}, 32'(div_zero), 32'(g.dz));
    q_hold = quotient;
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    extra = 0;
    repeat (idle_cycles) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk({tag, "_no_extra_done"}, extra, 0);
    chk({tag, "_q_hold"}, quotient, q_hold);
  endtask

  initial begin
    int extra;
    logic [31:0] rx, ry;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 0, 0, 0, 2);
    run_op("divzero", 32'h12345678, 32'd0, 1'b0, 0, 0, 0, 2);
    run_op("start_busy", 32'd50, 32'd5, 1'b0, 10, 32'd9, 32'd3, 40);
    run_op("umax_1", 32'hFFFFFFFF, 32'd1, 1'b0, 0, 0, 0, 1);
    run_op("small_big", 32'd5, 32'd10, 1'b0, 0, 0, 0, 1);
    run_op("umax_umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0, 0, 1);
    run_op("msb_3", 32'h80000000, 32'd3, 1'b0, 0, 0, 0, 1);
    run_op("neg7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 0, 0, 0, 1);
    run_op("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0, 0, 1);
    run_op("s_divzero", 32'hFFFFFFF0, 32'd0, 1'b1, 0, 0, 0, 1);
    run_op("s_7_neg2", 32'd7, 32'hFFFFFFFE, 1'b1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      rx = $urandom;
      ry = $urandom >> (i * 8);
      run_op("rand", rx, ry, 1'((i >> 1) & 1), 0, 0, 0, 1);
    end

    @(negedge clk);
    a = 32'd1000; b = 32'd3; sign = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("midrst_no_done", extra, 0);
    run_op("after_rst", 32'd1000, 32'd3, 1'b0, 0, 0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 The block SHALL have the port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have the port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-005 The block SHALL have the port sign, input, 1 bit: 1 = signed divide, 0 = unsigned divide; sampled with start.
REQ-006 The block SHALL have the port a, input, 32 bits: dividend; sampled with start.
REQ-007 The block SHALL have the port b, input, 32 bits: divisor; sampled with start.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while an operation is in progress (CALC state).
REQ-009 The block SHALL have the port done, output, 1 bit: single-cycle pulse marking that the results are valid.
REQ-010 The block SHALL have the port quotient, output, 32 bits: result quotient.
REQ-011 The block SHALL have the port remainder, output, 32 bits: result remainder.
REQ-012 The block SHALL have the port div_zero, output, 1 bit: high with done when b was 0.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-014 The FSM SHALL use these transitions:
- IDLE to CALC on start with b != 0.
- IDLE to DONE on start with b == 0.
- CALC to DONE after 32 iterations.
- DONE to IDLE unconditionally.
REQ-015 On the start edge the block SHALL latch a, b and sign into internal registers, clear the iteration counter, and clear the partial remainder.
REQ-016 Each CALC cycle SHALL perform one restoring-division step, 1 quotient bit per cycle, MSB first:
- Shift the 33-bit partial remainder left and bring in the next dividend bit.
- Subtract the divisor.
- Keep the difference if it is non-negative, otherwise restore.
REQ-017 For a nonzero divisor, done SHALL assert exactly 33 cycles after the clock edge that sampled start.
REQ-018 For a zero divisor, done SHALL assert exactly 1 cycle after the clock edge that sampled start.
REQ-019 done SHALL be high for exactly one cycle, in the DONE state.
REQ-020 quotient, remainder and div_zero SHALL update only on entry to DONE and SHALL hold until the next DONE or reset.
REQ-021 busy SHALL be 1 in CALC and 0 in IDLE and DONE.
REQ-022 start asserted in CALC or DONE SHALL be ignored, with no queuing.
REQ-023 Changes on a, b or sign after the start edge SHALL NOT affect the result.
REQ-024 Division by zero SHALL produce quotient = 32'hFFFFFFFF, remainder = latched a, and div_zero = 1.
REQ-025 div_zero SHALL be 0 for every nonzero divisor.
REQ-026 For unsigned operation the results SHALL satisfy a = quotient*b + remainder, with remainder < b.

Reset
REQ-027 While rst_n = 0 at a clock edge, the FSM SHALL go to IDLE and the counter and internal operands SHALL clear.
REQ-028 While rst_n = 0 at a clock edge, the outputs SHALL reset to busy = 0, done = 0, quotient = 0, remainder = 0 and div_zero = 0.
REQ-029 Reset asserted during CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-030 The first start accepted after rst_n returns high SHALL behave as from power-up.

Configuration
REQ-031 The macro DIV32_SEQ_SIGNED_EN SHALL select signed-divide support, as follows.
REQ-032 With DIV32_SEQ_SIGNED_EN defined and sign = 1, the block SHALL divide the operand magnitudes, then apply signs:
- The quotient is negated when sign(a) differs from sign(b).
- The remainder takes the sign of a (truncating division).
REQ-033 With DIV32_SEQ_SIGNED_EN defined and sign = 1, the special cases SHALL be:
- 32'h80000000 / 32'hFFFFFFFF gives quotient = 32'h80000000 and remainder = 0, with div_zero = 0.
- Division by zero follows REQ-024 unchanged.
REQ-034 Without DIV32_SEQ_SIGNED_EN, the sign port SHALL remain present but be ignored, all operations SHALL be unsigned, and latency SHALL be identical.

Verification
REQ-035 Unsigned divide: a = 100, b = 7, sign = 0, start for 1 cycle -> busy for 32 cycles; done at cycle 33; quotient = 14, remainder = 2, div_zero = 0.
REQ-036 Divide by zero: a = 32'h12345678, b = 0 -> done at cycle 1; quotient = 32'hFFFFFFFF, remainder = 32'h12345678, div_zero = 1.
REQ-037 Signed divide (macro defined): a = -7 (32'hFFFFFFF9), b = 2, sign = 1 -> quotient = 32'hFFFFFFFD, remainder = 32'hFFFFFFFF.
REQ-038 Signed overflow (macro defined): a = 32'h80000000, b = 32'hFFFFFFFF, sign = 1 -> quotient = 32'h80000000, remainder = 0.
REQ-039 Start while busy: a = 50, b = 5 with start; at cycle 10 a = 9, b = 3 with start -> single done at cycle 33; quotient = 10, remainder = 0.
REQ-040 Reset mid-operation: rst_n low at cycle 15 of CALC -> no done pulse; all outputs 0; a new start then completes normally.
